// File: rtl/calc_keys_pkg.sv
// Key codes, key-matrix map and scanner FSM states shared by the keypad
// scanner and CalculatorLogic.
package calc_keys_pkg;

  localparam logic [4:0] NULL  = 5'h00;
  localparam logic [4:0] CLEAR = 5'h01;
  localparam logic [4:0] PLUS  = 5'h02;
  localparam logic [4:0] MUL   = 5'h03;
  localparam logic [4:0] EQUAL = 5'h04;
  localparam int         DIGIT = 4;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE_PRESS,
    REPORT,
    HOLD
  } scan_state_t;

  function automatic logic [4:0] digit_code(input logic [3:0] d);
    logic [4:0] k;
    k        = '0;
    k[DIGIT] = 1'b1;
    k[3:0]   = d;
    return k;
  endfunction

  function automatic logic [4:0] key_lookup(input logic [1:0] row, input logic [2:0] col);
    logic [4:0] k;
    k = NULL;
    case (row)
      2'd0: case (col)
        3'd0: k = digit_code(4'h1);
        3'd1: k = digit_code(4'h2);
        3'd2: k = digit_code(4'h3);
        3'd3: k = digit_code(4'hA);
        3'd4: k = CLEAR;
        default: k = NULL;
      endcase
      2'd1: case (col)
        3'd0: k = digit_code(4'h4);
        3'd1: k = digit_code(4'h5);
        3'd2: k = digit_code(4'h6);
        3'd3: k = digit_code(4'hB);
        3'd4: k = PLUS;
        default: k = NULL;
      endcase
      2'd2: case (col)
        3'd0: k = digit_code(4'h7);
        3'd1: k = digit_code(4'h8);
        3'd2: k = digit_code(4'h9);
        3'd3: k = digit_code(4'hC);
        3'd4: k = MUL;
        default: k = NULL;
      endcase
      default: case (col)
        3'd0: k = digit_code(4'h0);
        3'd1: k = digit_code(4'hF);
        3'd2: k = digit_code(4'hE);
        3'd3: k = digit_code(4'hD);
        3'd4: k = EQUAL;
        default: k = NULL;
      endcase
    endcase
    return k;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
module sync_2ff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= RST_VAL;
      q       <= RST_VAL;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x5 key-matrix scanner: column scan, press/release debounce and keycode
// encoding with a one-cycle newKey strobe.
module keypad_scanner
  import calc_keys_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] rowIn,
  output logic [4:0] colOut,
  output logic [4:0] keycode,
  output logic       newKey
);

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CNT - 1);

  scan_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       col, col_nxt;
  logic [1:0]       row_q, row_nxt;
  logic [4:0]       key_nxt;
  logic             newkey_nxt;
  logic [3:0]       row_s;
  logic             any_low;
  logic [1:0]       low_row;

  function automatic logic [2:0] next_col(input logic [2:0] c);
    return (c == 3'd4) ? 3'd0 : c + 3'd1;
  endfunction

  sync_2ff #(.W(4), .RST_VAL(4'hF)) u_row_sync (
    .clk  (clock),
    .rst_n(reset),
    .d    (rowIn),
    .q    (row_s)
  );

  assign colOut  = ~(5'b00001 << col);
  assign any_low = ~&row_s;

  // Lowest-numbered active row wins when several rows are low
  always_comb begin
    casez (row_s)
      4'b???0: low_row = 2'd0;
      4'b??01: low_row = 2'd1;
      4'b?011: low_row = 2'd2;
      default: low_row = 2'd3;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= SCAN;
      cnt     <= '0;
      col     <= 3'd0;
      row_q   <= 2'd0;
      keycode <= NULL;
      newKey  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      col     <= col_nxt;
      row_q   <= row_nxt;
      keycode <= key_nxt;
      newKey  <= newkey_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + 1'b1;
    col_nxt    = col;
    row_nxt    = row_q;
    key_nxt    = keycode;
    newkey_nxt = 1'b0;
    case (state)
      SCAN: begin
        if (cnt == SCAN_LAST) begin
          cnt_nxt = '0;
          if (any_low) begin
            row_nxt   = low_row;
            state_nxt = DEBOUNCE_PRESS;
          end else begin
            col_nxt = next_col(col);
          end
        end
      end
      DEBOUNCE_PRESS: begin
        if (row_s[row_q]) begin
          cnt_nxt   = '0;
          col_nxt   = next_col(col);
          state_nxt = SCAN;
        end else if (cnt == DEB_LAST) begin
          cnt_nxt   = '0;
          key_nxt   = key_lookup(row_q, col);
          state_nxt = REPORT;
        end
      end
      // keycode has settled for one cycle; strobe on the way into HOLD
      REPORT: begin
        cnt_nxt    = '0;
        newkey_nxt = 1'b1;
        state_nxt  = HOLD;
      end
      HOLD: begin
        if (!row_s[row_q]) begin
          cnt_nxt = '0;
        end else if (cnt == DEB_LAST) begin
          cnt_nxt   = '0;
          key_nxt   = NULL;
          col_nxt   = 3'd0;
          state_nxt = SCAN;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = SCAN;
      end
    endcase
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: key-matrix model, table of single presses,
// and hand-written bounce, rollover and reset sequences.
module tb_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 8;

  logic       clock;
  logic       reset;
  logic [3:0] rowIn;
  logic [4:0] colOut;
  logic [4:0] keycode;
  logic       newKey;

  logic [19:0] pressed;
  int          errors;
  int          checks;
  int          pulses;
  logic [4:0]  exp_q[$];
  logic        prev_new;
  logic [4:0]  prev_key;

  typedef struct {
    logic [1:0] row;
    logic [2:0] col;
    logic [4:0] code;
    string      name;
  } vec_t;

  vec_t tbl[7];

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
    .clock  (clock),
    .reset  (reset),
    .rowIn  (rowIn),
    .colOut (colOut),
    .keycode(keycode),
    .newKey (newKey)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Passive matrix: a pressed key pulls its row low while its column is driven
  always_comb begin
    rowIn = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++)
        if (pressed[r*5+c] && !colOut[c]) rowIn[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (newKey) begin
      pulses++;
      check("newKey_width", {31'd0, prev_new}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_newKey", {27'd0, keycode}, 32'hFFFF);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        check("sb_keycode", {27'd0, keycode}, {27'd0, e});
        check("sb_key_before_strobe", {27'd0, prev_key}, {27'd0, e});
      end
    end
    prev_new = newKey;
    prev_key = keycode;
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic set_key(input int r, input int c, input logic v);
    pressed[r*5+c] = v;
  endtask

  task automatic wait_pulse(input int target, input string name);
    int n;
    n = 0;
    while (pulses < target && n < 300) begin
      tick();
      n++;
    end
    check(name, pulses, target);
  endtask

  task automatic wait_clear(input string name);
    int n;
    n = 0;
    while (keycode !== 5'h00 && n < 100) begin
      tick();
      n++;
    end
    check({name, "_key"}, {27'd0, keycode}, 32'h00);
    check({name, "_col"}, {27'd0, colOut}, 32'h1E);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    pulses   = 0;
    pressed  = '0;
    prev_new = 1'b0;
    prev_key = 5'h00;
    reset    = 1'b0;

    tbl[0] = '{2'd1, 3'd1, 5'h15, "key5"};
    tbl[1] = '{2'd3, 3'd4, 5'h04, "EQUAL"};
    tbl[2] = '{2'd0, 3'd3, 5'h1A, "keyA"};
    tbl[3] = '{2'd0, 3'd4, 5'h01, "CLEAR"};
    tbl[4] = '{2'd3, 3'd0, 5'h10, "key0"};
    tbl[5] = '{2'd2, 3'd4, 5'h03, "MUL"};
    tbl[6] = '{2'd3, 3'd1, 5'h1F, "keyF"};

    repeat (3) tick();
    check("rst_colOut", {27'd0, colOut}, 32'h1E);
    check("rst_keycode", {27'd0, keycode}, 32'h00);
    check("rst_newKey", {31'd0, newKey}, 32'd0);

    reset = 1'b1;
    #1;
    for (int i = 0; i < 24; i++) begin
      logic [4:0] ec;
      ec = ~(5'b00001 << ((i / SCAN_DIV) % 5));
      check("col_scan", {27'd0, colOut}, {27'd0, ec});
      tick();
    end

    for (int i = 0; i < 7; i++) begin
      int target;
      target = pulses + 1;
      exp_q.push_back(tbl[i].code);
      set_key(tbl[i].row, tbl[i].col, 1'b1);
      wait_pulse(target, {tbl[i].name, "_pulse"});
      repeat (40) tick();
      check({tbl[i].name, "_held_key"}, {27'd0, keycode}, {27'd0, tbl[i].code});
      check({tbl[i].name, "_one_pulse"}, pulses, target);
      set_key(tbl[i].row, tbl[i].col, 1'b0);
      wait_clear({tbl[i].name, "_release"});
    end

    begin
      int   base;
      logic seen_key;
      base     = pulses;
      seen_key = 1'b0;
      for (int i = 0; i < 60; i++) begin
        if ((i / 3) % 2 == 0) set_key(0, 0, 1'b1);
        else                  set_key(0, 0, 1'b0);
        tick();
        if (keycode !== 5'h00) seen_key = 1'b1;
      end
      check("bounce_no_pulse", pulses, base);
      check("bounce_no_key", {31'd0, seen_key}, 32'd0);
      exp_q.push_back(5'h11);
      set_key(0, 0, 1'b1);
      wait_pulse(base + 1, "bounce_stable_pulse");
      repeat (30) tick();
      check("bounce_single", pulses, base + 1);
      set_key(0, 0, 1'b0);
      wait_clear("bounce_release");
    end

    begin
      int base;
      base = pulses;
      exp_q.push_back(5'h17);
      set_key(2, 0, 1'b1);
      wait_pulse(base + 1, "hold7_pulse");
      set_key(1, 4, 1'b1);
      repeat (500) tick();
      check("hold7_single", pulses, base + 1);
      check("hold7_key", {27'd0, keycode}, 32'h17);
      exp_q.push_back(5'h02);
      set_key(2, 0, 1'b0);
      wait_clear("hold7_release");
      wait_pulse(base + 2, "plus_pulse");
      check("plus_key", {27'd0, keycode}, 32'h02);
      set_key(1, 4, 1'b0);
      wait_clear("plus_release");
    end

    begin
      int base;
      base = pulses;
      exp_q.push_back(5'h12);
      set_key(0, 1, 1'b1);
      wait_pulse(base + 1, "key2_pulse");
      repeat (5) tick();
      check("key2_hold", {27'd0, keycode}, 32'h12);
      reset = 1'b0;
      #1;
      check("async_rst_key", {27'd0, keycode}, 32'h00);
      check("async_rst_col", {27'd0, colOut}, 32'h1E);
      check("async_rst_new", {31'd0, newKey}, 32'd0);
      repeat (2) tick();
      reset = 1'b1;
      exp_q.push_back(5'h12);
      repeat (DEBOUNCE_CNT) tick();
      check("post_rst_no_pulse", pulses, base + 1);
      check("post_rst_key_null", {27'd0, keycode}, 32'h00);
      wait_pulse(base + 2, "post_rst_fresh_pulse");
      set_key(0, 1, 1'b0);
      wait_clear("key2_release");
    end

    repeat (5) tick();
    check("sb_queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a 4-row x 5-column calculator key matrix, debounces presses and releases, and encodes each accepted press into the 5-bit keycode / newKey protocol consumed by CalculatorLogic. It is the initiator (producer) side of the key interface. It sits between the board keypad pins and CalculatorLogic, sharing its single system clock.

Parameters:
SCAN_DIV, 1000, clock cycles each column is driven before its rows are sampled (settle time); must be >= 4.
DEBOUNCE_CNT, 50000, consecutive stable clock cycles required to accept a press or a release; must be >= 2.

Ports:
clock  in  1  system clock; all logic on the rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset).
rowIn  in  4  matrix rows, active-low (external pull-ups); asynchronous to clock.
colOut  out  5  matrix column drives, active-low, one-hot-low; exactly one bit is 0 at all times.
keycode  out  5  encoded key; NULL (5'h00) when no key is accepted.
newKey  out  1  single-cycle pulse marking a newly accepted key.

Behaviour:
- Reset values: colOut=5'b11110 (column 0 driven), keycode=5'h00, newKey=0, state=SCAN, all counters 0. Reset takes effect immediately and at any time, including mid-debounce or mid-hold; no pending key survives it.
- rowIn passes through a 2-FF synchroniser. All row decisions use the synchronised value, which adds 2 cycles of latency.
- Key map (row,col -> key). Row0: 1,2,3,A,CLEAR. Row1: 4,5,6,B,PLUS. Row2: 7,8,9,C,MUL. Row3: 0,F,E,D,EQUAL.
- Encoding: hex digit d (0..F) -> {1'b1, d}, giving 5'h10..5'h1F. CLEAR=5'h01, PLUS=5'h02, MUL=5'h03, EQUAL=5'h04. NULL=5'h00.
- States: SCAN, DEBOUNCE_PRESS, REPORT, HOLD.
- SCAN: drive the current column and count SCAN_DIV cycles. At terminal count, sample rows.
  - Any row low: latch the lowest-numbered low row plus the current column, then go to DEBOUNCE_PRESS. The column stays driven.
  - No row low: advance to the next column, wrapping 4->0, and restart the count.
- DEBOUNCE_PRESS: the latched row must stay low for DEBOUNCE_CNT consecutive cycles.
  - Any high sample: abort, advance to the next column, return to SCAN. No output changes.
  - On completion: keycode <= encoded key, go to REPORT.
- REPORT: lasts 1 cycle with newKey=0, so keycode is stable one cycle before the strobe. Next cycle: newKey=1 for exactly 1 cycle, go to HOLD.
- HOLD: the column stays driven and keycode is held.
  - The latched row must read high for DEBOUNCE_CNT consecutive cycles. Any low sample restarts the count.
  - On completion: keycode <= NULL, colOut <= column 0, go to SCAN.
- Multiple keys: no rollover. Other keys pressed during DEBOUNCE_PRESS or HOLD are ignored. At most one newKey per physical press, regardless of hold length.
- Latency: from the first synchronised low sample in the valid sample window, keycode updates after DEBOUNCE_CNT cycles and newKey follows 1 cycle later.
- Counters are sized with $clog2 of their parameter and saturate-free: they reset on every state entry.

Decomposition:
- Shared package calc_keys_pkg holds:
  - keycode localparams NULL, CLEAR, PLUS, MUL, EQUAL and the DIGIT flag bit (bit 4);
  - the 4x5 key-map lookup function;
  - the FSM state enum.
- CalculatorLogic and its testbench import the same package.
- One sub-module: sync_2ff, a parameterised-width 2-flop synchroniser with async active-low reset, instantiated for rowIn.

Test Plan:
- Reset: hold reset=0 for 3 cycles with rowIn=4'hF -> colOut=5'b11110, keycode=5'h00, newKey=0. Release -> colOut cycles 11110, 11101, 11011, 10111, 01111, 11110, each held SCAN_DIV cycles.
- Clean press, digit 5 (row1,col1), SCAN_DIV=4, DEBOUNCE_CNT=8: pull rowIn[1] low while colOut[1]=0 and hold 40 cycles -> keycode=5'h15, newKey high exactly 1 cycle, one cycle after keycode changes. Release for >=8 cycles -> keycode=5'h00, scan restarts at column 0.
- Control key EQUAL (row3,col4) -> keycode=5'h04. Key A (row0,col3) -> keycode=5'h1A. Each gives a single newKey pulse.
- Bounce: toggle rowIn[0] low/high every 3 cycles during debounce with DEBOUNCE_CNT=8 -> no newKey, keycode stays 5'h00. Then hold stable low -> exactly one newKey.
- Long hold plus second key: hold key 7 for 500 cycles while also pressing PLUS -> exactly one newKey with keycode=5'h17, no PLUS report. Release 7 only -> keycode=5'h00, then PLUS is detected on the next scan with keycode=5'h02.
- Reset mid-HOLD: assert reset while keycode=5'h12 -> keycode=5'h00 and colOut=5'b11110 immediately (asynchronously). No newKey after release while the key remains pressed, until a fresh debounce completes.
